// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-outstanding memory controller.
// Optional macro MEM_ARB_ROUND_ROBIN_EN replaces fixed data-over-fetch priority with round robin.
`timescale 1ns/1ps

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 12
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif

module mem_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                      clk,
    input  logic                      sync_reset,

    input  logic                      fetch_req,
    input  logic [`MEM_ADDR_BITS-1:0] fetch_addr,
    output logic                      fetch_grant,
    output logic                      fetch_ack,
    output logic [`XLEN-1:0]          fetch_rdata,

    input  logic                      data_req,
    input  logic [`MEM_ADDR_BITS-1:0] data_addr,
    input  logic [`XLEN_BYTES-1:0]    data_we,
    input  logic [`XLEN-1:0]          data_wdata,
    output logic                      data_grant,
    output logic                      data_ack,
    output logic [`XLEN-1:0]          data_rdata,

    output logic [`MEM_ADDR_BITS-1:0] mem_addr,
    output logic [`XLEN_BYTES-1:0]    mem_write_en,
    output logic [`XLEN-1:0]          mem_write_data,
    output logic                      mem_read_en,
    input  logic [`XLEN-1:0]          mem_read_data,
    input  logic                      mem_read_ack,

    output logic                      err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t                      state_q, state_d;
    logic                        owner_q, owner_d;   // 1 = data port, 0 = fetch port
    logic [`MEM_ADDR_BITS-1:0]   addr_q,  addr_d;
    logic [`XLEN_BYTES-1:0]      we_q,    we_d;
    logic [`XLEN-1:0]            wdata_q, wdata_d;
    logic [3:0]                  cnt_q,   cnt_d;

    logic                        pick_data;
    logic                        is_read;
    logic                        in_issue;
    logic                        in_wait;
    logic                        timeout_hit;
    logic                        ack_any;
    logic [`XLEN-1:0]            rdata_any;

    assign is_read = (we_q == '0);

    // owner_q doubles as the most-recent-grant record for round robin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_data = data_req && (!fetch_req || !owner_q);
`else
    assign pick_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b1;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_req || data_req) begin
                    owner_d = pick_data;
                    addr_d  = pick_data ? data_addr  : fetch_addr;
                    we_d    = pick_data ? data_we    : '0;
                    wdata_d = pick_data ? data_wdata : '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!is_read || mem_read_ack || cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates acks/errors combinationally so an aborted transaction stays silent
    always_comb begin
        in_issue       = (state_q == S_ISSUE);
        in_wait        = (state_q == S_WAIT) && !sync_reset;
        timeout_hit    = in_wait && is_read && !mem_read_ack && (cnt_q == CNT_LAST);
        ack_any        = in_wait && (!is_read || mem_read_ack || timeout_hit);
        rdata_any      = (in_wait && is_read && mem_read_ack) ? mem_read_data : '0;

        mem_addr       = in_issue ? addr_q : '0;
        mem_read_en    = in_issue && is_read;
        mem_write_en   = in_issue ? we_q : '0;
        mem_write_data = in_issue ? wdata_q : '0;

        fetch_grant    = in_issue && !owner_q;
        data_grant     = in_issue &&  owner_q;
        fetch_ack      = ack_any && !owner_q;
        data_ack       = ack_any &&  owner_q;
        fetch_rdata    = owner_q ? '0 : rdata_any;
        data_rdata     = owner_q ? rdata_any : '0;
        err_timeout    = timeout_hit;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single transactions plus
// directed sequences for arbitration, timeout, reset-in-WAIT and spurious ack.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        fetch_req, data_req;
    logic [11:0] fetch_addr, data_addr;
    logic [3:0]  data_we;
    logic [31:0] data_wdata;
    logic        fetch_grant, fetch_ack, data_grant, data_ack;
    logic [31:0] fetch_rdata, data_rdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_read_en, mem_read_ack, err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_grant(fetch_grant), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_wdata(data_wdata),
        .data_grant(data_grant), .data_ack(data_ack), .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_en(mem_read_en), .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .err_timeout(err_timeout)
    );

    // One-cycle memory model with byte-enable writes
    logic [31:0] mem [0:4095];
    logic        rack_q = 1'b0;
    logic [31:0] rdat_q = '0;
    logic        ack_en = 1'b1;
    logic        spur   = 1'b0;
    assign mem_read_ack  = (rack_q & ack_en) | spur;
    assign mem_read_data = rdat_q;

    always @(posedge clk) begin
        rack_q <= mem_read_en;
        rdat_q <= mem[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_write_en[b]) mem[mem_addr][8*b +: 8] <= mem_write_data[8*b +: 8];
    end

    typedef struct {
        string       name;
        bit          is_data;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " ctl"}, 32'({fetch_grant, data_grant, fetch_ack, data_ack,
                              mem_read_en, mem_write_en, err_timeout}), 32'd0);
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, " wdata"}, mem_write_data, 32'd0);
        chk({nm, " rdata"}, fetch_rdata | data_rdata, 32'd0);
    endtask

    task automatic do_xact(input vec_t v);
        logic [31:0] gexp;
        gexp = v.is_data ? 32'd1 : 32'd2;
        @(negedge clk);
        if (v.is_data) begin
            data_req = 1'b1; data_addr = v.addr; data_we = v.we; data_wdata = v.wdata;
        end else begin
            fetch_req = 1'b1; fetch_addr = v.addr;
        end
        @(posedge clk); #1;
        chk({v.name, " grant"}, 32'({fetch_grant, data_grant}), gexp);
        chk({v.name, " rd_en"}, 32'(mem_read_en), (v.we == 4'd0) ? 32'd1 : 32'd0);
        chk({v.name, " wr_en"}, 32'(mem_write_en), 32'(v.we));
        chk({v.name, " addr"}, 32'(mem_addr), 32'(v.addr));
        if (v.we != 4'd0) chk({v.name, " wdata"}, mem_write_data, v.wdata);
        @(negedge clk);
        fetch_req = 1'b0; data_req = 1'b0; data_we = '0;
        @(posedge clk); #1;
        chk({v.name, " ack"}, 32'({fetch_ack, data_ack}), gexp);
        chk({v.name, " rdata"}, v.is_data ? data_rdata : fetch_rdata, v.exp);
        chk({v.name, " other rdata"}, v.is_data ? fetch_rdata : data_rdata, 32'd0);
        chk({v.name, " err"}, 32'(err_timeout), 32'd0);
        chk({v.name, " rd_en off"}, 32'({mem_read_en, mem_write_en}), 32'd0);
        @(posedge clk); #1;
        chk({v.name, " idle"}, 32'({fetch_grant, data_grant, fetch_ack, data_ack}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = 32'h12345678;
        mem[12'h020] = 32'h11223344;

        vec[0] = '{"fetch rd 010", 1'b0, 4'b0000, 12'h010, 32'h0,        32'h12345678};
        vec[1] = '{"data wr 020",  1'b1, 4'b0011, 12'h020, 32'hAABBCCDD, 32'h0};
        vec[2] = '{"data rd 020",  1'b1, 4'b0000, 12'h020, 32'h0,        32'h1122CCDD};
        vec[3] = '{"fetch rd 020", 1'b0, 4'b0000, 12'h020, 32'h0,        32'h1122CCDD};
        vec[4] = '{"data wr 030",  1'b1, 4'b1100, 12'h030, 32'hCAFEF00D, 32'h0};
        vec[5] = '{"fetch rd 030", 1'b0, 4'b0000, 12'h030, 32'h0,        32'hCAFE0000};
        vec[6] = '{"data rd 010",  1'b1, 4'b0000, 12'h010, 32'h0,        32'h12345678};

        sync_reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_addr = '0; data_we = '0; data_wdata = '0;
        repeat (2) @(posedge clk);
        #1 chk_quiet("reset");
        @(negedge clk) sync_reset = 1'b0;

        for (int i = 0; i < 7; i++) do_xact(vec[i]);

        // Both ports request continuously for four transactions
        @(negedge clk) sync_reset = 1'b1;
        @(negedge clk) sync_reset = 1'b0;
        fetch_req = 1'b1; fetch_addr = 12'h010;
        data_req  = 1'b1; data_addr  = 12'h020; data_we = '0;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ge;
            @(posedge clk); #1;
            if (i % 3 == 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                ge = (i % 6 == 0) ? 32'd2 : 32'd1;
`else
                ge = 32'd1;
`endif
            end else begin
                ge = 32'd0;
            end
            chk($sformatf("arb grant c%0d", i), 32'({fetch_grant, data_grant}), ge);
        end
        @(negedge clk);
        fetch_req = 1'b0; data_req = 1'b0;
        @(posedge clk); #1;

        // Read timeout with the memory never answering
        ack_en = 1'b0;
        @(negedge clk) begin fetch_req = 1'b1; fetch_addr = 12'h040; end
        @(posedge clk); #1;
        chk("to grant", 32'(fetch_grant), 32'd1);
        @(negedge clk) fetch_req = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            @(posedge clk); #1;
            chk($sformatf("to err w%0d", k), 32'(err_timeout), (k == int'(TO)) ? 32'd1 : 32'd0);
            chk($sformatf("to ack w%0d", k), 32'({fetch_ack, data_ack}), (k == int'(TO)) ? 32'd2 : 32'd0);
            chk($sformatf("to rdata w%0d", k), fetch_rdata, 32'd0);
        end
        @(posedge clk); #1;
        chk("to after", 32'({err_timeout, fetch_ack, fetch_grant}), 32'd0);
        @(negedge clk) ack_en = 1'b1;
        do_xact(vec[0]);

        // Reset arriving during the WAIT cycle of a read
        @(negedge clk) begin fetch_req = 1'b1; fetch_addr = 12'h010; end
        @(posedge clk); #1;
        chk("rw grant", 32'(fetch_grant), 32'd1);
        @(negedge clk) fetch_req = 1'b0;
        @(posedge clk);
        @(negedge clk) sync_reset = 1'b1;
        #1;
        chk("rw mem ack present", 32'(mem_read_ack), 32'd1);
        chk("rw ack suppressed", 32'({fetch_ack, data_ack, err_timeout}), 32'd0);
        chk("rw rdata", fetch_rdata, 32'd0);
        @(posedge clk); #1;
        chk_quiet("rw after reset");
        @(negedge clk) sync_reset = 1'b0;
        do_xact(vec[0]);

        // Spurious memory ack while idle
        @(negedge clk) spur = 1'b1;
        #1 chk_quiet("spur same cycle");
        @(posedge clk); #1;
        chk_quiet("spur next cycle");
        @(negedge clk) spur = 1'b0;
        do_xact(vec[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ACK_TIMEOUT, default 4, giving the WAIT cycles without mem_read_ack before a read is aborted (legal range 2..15).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port sync_reset, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The module SHALL have ports fetch_req / fetch_addr, inputs, 1 / `MEM_ADDR_BITS: the instruction-fetch read request and word address.
REQ-005 The module SHALL have ports fetch_grant / fetch_ack / fetch_rdata, outputs, 1 / 1 / `XLEN: request accepted, read complete, read data.
REQ-006 The module SHALL have ports data_req / data_addr / data_we / data_wdata, inputs, 1 / `MEM_ADDR_BITS / `XLEN_BYTES / `XLEN: the data-port request; any data_we bit set makes it a write.
REQ-007 The module SHALL have ports data_grant / data_ack / data_rdata, outputs, 1 / 1 / `XLEN, with the same meaning as the fetch-port outputs.
REQ-008 The module SHALL have ports mem_addr / mem_write_en / mem_write_data / mem_read_en, outputs, `MEM_ADDR_BITS / `XLEN_BYTES / `XLEN / 1, driving the memory controller.
REQ-009 The module SHALL have ports mem_read_data / mem_read_ack, inputs, `XLEN / 1, returned by the memory controller.
REQ-010 The module SHALL have port err_timeout, output, 1, a one-cycle pulse when a read is aborted.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE and WAIT, with one transaction outstanding at most.
- IDLE: any req asserted -> latch owner, addr, we, wdata; registered grant pulse to owner (high during the ISSUE cycle) -> ISSUE.
- ISSUE: drive registered mem_addr; mem_read_en=1 if we==0, else mem_write_en=we with mem_write_data=wdata, both for exactly one cycle; clear timeout counter -> WAIT.
- WAIT, write: owner ack=1 this cycle -> IDLE.
- WAIT, read: owner ack=mem_read_ack and owner rdata=mem_read_data, combinational pass-through; ack -> IDLE.
REQ-012 Read latency SHALL be fixed: request accepted at edge E0, mem_read_en high E0-E1, owner ack high E1-E2 when memory answers in one cycle.
REQ-013 A requester SHALL hold req, addr, we and wdata stable until it sees grant; the arbiter SHALL ignore further input changes until it returns to IDLE.
REQ-014 A req still high in the ack cycle SHALL NOT be accepted before the next IDLE cycle; there are no back-to-back grants without an IDLE cycle between them.
REQ-015 Without the configuration macro, data_req SHALL win over fetch_req when both are high in IDLE.
REQ-016 A read timeout SHALL work as follows:
- The counter increments each WAIT cycle without mem_read_ack.
- On reaching ACK_TIMEOUT: err_timeout=1, owner ack=1 with rdata=0, -> IDLE.
REQ-017 A mem_read_ack arriving outside WAIT, or for a write, SHALL be ignored.
REQ-018 A grant or ack SHALL NOT be asserted to the non-owner port; non-owner rdata SHALL be 0.

Reset
REQ-019 sync_reset SHALL force state IDLE, counter 0, owner=data, and all outputs 0 (grants, acks, mem_read_en, mem_write_en, mem_addr, mem_write_data, err_timeout, rdata) from the next cycle.
REQ-020 A reset mid-transaction SHALL drop the transaction silently, with no ack and no error; a write in ISSUE during the reset edge SHALL still have its single strobe cycle.
REQ-021 sync_reset SHALL take priority over every request and ack in the same cycle.

Configuration
REQ-022 When `MEM_ARB_ROUND_ROBIN_EN is defined, simultaneous requests in IDLE SHALL go to the port not granted most recently (fetch first after reset); a lone request is always granted.
REQ-023 When `MEM_ARB_ROUND_ROBIN_EN is undefined, REQ-015 fixed priority SHALL apply, and no last-owner register exists.

Verification
REQ-024 The bench SHALL cover a fetch read of addr 0x010 holding 0x12345678 -> fetch_grant at E0+1, mem_read_en one cycle, fetch_ack with fetch_rdata=0x12345678 at E1-E2.
REQ-025 The bench SHALL cover a data write of addr 0x020, we=4'b0011, wdata=0xAABBCCDD -> mem_write_en=4'b0011 for one cycle, data_ack next cycle; a readback returns 0x????CCDD with the upper bytes unchanged.
REQ-026 The bench SHALL cover fetch_req and data_req held high for 4 transactions -> fixed priority: 4 data grants; with `MEM_ARB_ROUND_ROBIN_EN: fetch, data, fetch, data.
REQ-027 The bench SHALL cover mem_read_ack tied low with ACK_TIMEOUT=4 -> err_timeout pulse 4 cycles into WAIT, owner ack with rdata=0, then IDLE.
REQ-028 The bench SHALL cover sync_reset asserted in the WAIT cycle of a read -> no ack, all outputs 0 next cycle, and a new fetch_req granted normally afterwards.
REQ-029 The bench SHALL cover a spurious mem_read_ack while IDLE -> no ack on either port and no state change.
